demux_destino: RTL and testbench

Downstream stage of the transaction-layer arbiter: takes the single arbitrated stream (8-bit data plus 4-bit destination tag) and steers each word into one of four output FIFOs selected by the tag. Each output FIFO is drained independently by its consumer via a pop strobe. Backpressure to the arbiter comes from a ready signal that drops when the targeted FIFO is full.

---
 rtl/demux_destino.sv | 83 ++++++++
 tb/tb_demux_destino.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/demux_destino.sv
// demux_destino: steers tagged words into four show-ahead FIFOs; optional DEMUX_ERR_CNT_EN counts and drops invalid tags
// Ports: clk, reset (sync, active-high); valid_in/data_in/dest_in in, ready_out out;
//        popN in, data_outN/emptyN/almost_fullN out per FIFO; err_cnt out (DEMUX_ERR_CNT_EN only).
module demux_destino #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 4,
  parameter int DEPTH  = 4,
  parameter int AF_TH  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              ready_out,
  input  logic              pop0,
  input  logic              pop1,
  input  logic              pop2,
  input  logic              pop3,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic              empty0,
  output logic              empty1,
  output logic              empty2,
  output logic              empty3,
  output logic              almost_full0,
  output logic              almost_full1,
  output logic              almost_full2,
  output logic              almost_full3
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] sel;
  logic invalid, accept;
  logic [3:0] pop, full, empty, af, wr_en, rd_en;
  logic [DATA_W-1:0] head [4];
  assign sel = dest_in[1:0];
`ifdef DEMUX_ERR_CNT_EN
  assign invalid = |dest_in[DEST_W-1:2];
  always_ff @(posedge clk)
    if (reset) err_cnt <= '0;
    else if (valid_in && invalid && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`else
  logic unused_tag;
  assign unused_tag = ^dest_in[DEST_W-1:2];
  assign invalid = 1'b0;
`endif
  // invalid tags are always taken (and dropped) so they never stall the arbiter
  assign ready_out = invalid | ~full[sel];
  assign accept = valid_in & ready_out & ~invalid;
  assign pop = {pop3, pop2, pop1, pop0};
  for (genvar g = 0; g < 4; g++) begin : g_fifo
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ;
    assign wr_en[g] = accept && sel == g;
    assign rd_en[g] = pop[g] & ~empty[g];
    assign empty[g] = occ == '0;
    assign full[g] = occ == (AW+1)'(DEPTH);
    assign af[g] = occ >= (AW+1)'(AF_TH);
    assign head[g] = empty[g] ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
      if (wr_en[g]) mem[wr_ptr] <= data_in;
    always_ff @(posedge clk)
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ <= '0;
      end else begin
        if (wr_en[g]) wr_ptr <= wr_ptr + AW'(1);
        if (rd_en[g]) rd_ptr <= rd_ptr + AW'(1);
        occ <= occ + (AW+1)'(wr_en[g]) - (AW+1)'(rd_en[g]);
      end
  end
  assign {data_out3, data_out2, data_out1, data_out0} = {head[3], head[2], head[1], head[0]};
  assign {empty3, empty2, empty1, empty0} = empty;
  assign {almost_full3, almost_full2, almost_full1, almost_full0} = af;
endmodule

// File: tb/tb_demux_destino.sv
// tb_demux_destino: random + directed self-checking bench with a queue-based reference model
module tb_demux_destino;
  logic clk = 0, reset = 1, valid_in = 0;
  logic [7:0] data_in = 0;
  logic [3:0] dest_in = 0;
  logic ready_out;
  logic pop0 = 0, pop1 = 0, pop2 = 0, pop3 = 0;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic empty0, empty1, empty2, empty3;
  logic almost_full0, almost_full1, almost_full2, almost_full3;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  int checks = 0, fails = 0;
  int m_err = 0;
  logic [7:0] q [4][$];

  demux_destino dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .dest_in(dest_in),
    .ready_out(ready_out), .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
    .almost_full0(almost_full0), .almost_full1(almost_full1),
    .almost_full2(almost_full2), .almost_full3(almost_full3)
`ifdef DEMUX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic bit m_inv(logic [3:0] t);
`ifdef DEMUX_ERR_CNT_EN
    return t[3:2] != 0;
`else
    return 0;
`endif
  endfunction

  task automatic compare();
    logic [7:0] d [4];
    logic [3:0] e, a;
    d = '{data_out0, data_out1, data_out2, data_out3};
    e = {empty3, empty2, empty1, empty0};
    a = {almost_full3, almost_full2, almost_full1, almost_full0};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("data_out%0d", i), d[i], q[i].size() ? q[i][0] : 8'd0);
      chk($sformatf("empty%0d", i), e[i], q[i].size() == 0);
      chk($sformatf("almost_full%0d", i), a[i], q[i].size() >= 3);
    end
    chk("ready_out", ready_out, m_inv(dest_in) || q[dest_in[1:0]].size() < 4);
`ifdef DEMUX_ERR_CNT_EN
    chk("err_cnt", err_cnt, m_err);
`endif
  endtask

  task automatic step(bit v, logic [7:0] d, logic [3:0] t, logic [3:0] p, bit r = 0);
    bit acc;
    @(negedge clk);
    reset = r; valid_in = v; data_in = d; dest_in = t;
    {pop3, pop2, pop1, pop0} = p;
    #1 compare();
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      m_err = 0;
    end else begin
      acc = v && !m_inv(t) && q[t[1:0]].size() < 4;
      for (int i = 0; i < 4; i++) if (p[i] && q[i].size()) void'(q[i].pop_front());
      if (acc) q[t[1:0]].push_back(d);
      if (v && m_inv(t) && m_err < 255) m_err++;
    end
  endtask

  initial begin
    logic [7:0] order [4];
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0);
    #1;
    chk("lit_rst_empty0", empty0, 1);
    chk("lit_rst_data_out3", data_out3, 0);
    chk("lit_rst_ready", ready_out, 1);
    chk("lit_rst_af2", almost_full2, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(10 * i), 4'(i), 0);
    step(0, 0, 0, 0);
    #1;
    chk("lit_route_d0", data_out0, 0);
    chk("lit_route_d1", data_out1, 10);
    chk("lit_route_d2", data_out2, 20);
    chk("lit_route_d3", data_out3, 30);
    chk("lit_route_e0", empty0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step(1, 8'(i), 1, 0);
      if (i == 3) begin #1 chk("lit_af1_after3", almost_full1, 1); end
    end
    #1 chk("lit_full_ready", ready_out, 0);
    step(1, 5, 1, 4'b0010);
    #1 chk("lit_ready_after_pop", ready_out, 1);
    chk("lit_head_after_pop", data_out1, 2);
    step(1, 5, 1, 0);
    order = '{8'd2, 8'd3, 8'd4, 8'd5};
    for (int i = 0; i < 4; i++) begin
      #1 chk("lit_order", data_out1, order[i]);
      step(0, 0, 0, 4'b0010);
    end
    #1 chk("lit_drained", empty1, 1);
    step(1, 7, 1, 0);
    step(1, 8, 1, 0);
    step(1, 9, 1, 4'b0011);
    step(0, 0, 0, 0);
    #1;
    chk("lit_wp_head", data_out1, 8);
    chk("lit_wp_af", almost_full1, 0);
    chk("lit_pop_empty0", data_out0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 8'(40 + i), 2, 0);
    step(1, 99, 2, 0, 1);
    step(0, 0, 0, 0);
    #1;
    chk("lit_rst_mid_e2", empty2, 1);
    chk("lit_rst_mid_d2", data_out2, 0);
`ifdef DEMUX_ERR_CNT_EN
    for (int i = 0; i < 3; i++) step(1, 8'(i), 4'd5, 0);
    step(0, 0, 0, 0);
    #1 chk("lit_err3", err_cnt, 3);
    for (int i = 0; i < 257; i++) step(1, 8'(i), 4'd5, 0);
    step(0, 0, 0, 0);
    #1 chk("lit_err_sat", err_cnt, 255);
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(3) != 0, 8'($urandom), 4'($urandom),
           4'($urandom) & 4'($urandom), $urandom_range(199) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
